// File: rtl/multiplier_32b_rr_arb.sv
// Round-robin arbiter and sequencer sharing one registered 32x32 multiplier among NUM_REQ requesters.
// Optional macro MUL_CLR_EN adds a one-cycle CLR state that zeroes the multiplier after each response.
module multiplier_32b_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic [NUM_REQ-1:0]    iReqValid,
    output logic [NUM_REQ-1:0]    oReqReady,
    input  logic [NUM_REQ*32-1:0] iReqData0,
    input  logic [NUM_REQ*32-1:0] iReqData1,
    output logic                  oMulEn,
    output logic                  oMulClr,
    output logic [31:0]           oMulData0,
    output logic [31:0]           oMulData1,
    input  logic [63:0]           iMulData,
    output logic [NUM_REQ-1:0]    oRspValid,
    output logic [63:0]           oRspData,
    input  logic                  iRspReady,
    output logic                  oBusy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
`ifdef MUL_CLR_EN
        ,
        ST_CLR   = 2'd3
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;

    logic [31:0]      req_a [NUM_REQ];
    logic [31:0]      req_b [NUM_REQ];
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] win_next;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_a[k] = iReqData0[32*k +: 32];
            req_b[k] = iReqData1[32*k +: 32];
        end
    end

    // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-2 NUM_REQ never indexes past the last requester.
    always_comb begin
        found    = 1'b0;
        win_idx  = ptr_q;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!found && iReqValid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign win_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        oReqReady = '0;
        oMulEn    = 1'b0;
        oMulClr   = 1'b0;
        oRspValid = '0;
        oRspData  = '0;
        oBusy     = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    // Ready is gated by reset so nothing is offered while the block is held in reset.
                    oReqReady = iRstN ? (NUM_REQ'(1) << win_idx) : '0;
                    state_d   = ST_ISSUE;
                    ptr_d     = win_next;
                    grant_d   = win_idx;
                    opa_d     = req_a[win_idx];
                    opb_d     = req_b[win_idx];
                end
            end
            ST_ISSUE: begin
                oMulEn  = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                oRspValid = NUM_REQ'(1) << grant_q;
                oRspData  = iMulData;
                if (iRspReady) begin
`ifdef MUL_CLR_EN
                    state_d = ST_CLR;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef MUL_CLR_EN
            ST_CLR: begin
                oMulClr = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The multiplier holds its inputs outside ISSUE, so operands stay on the last latched pair.
    assign oMulData0 = opa_q;
    assign oMulData1 = opb_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the operand latches are reset too, because their values are visible on oMulData0/1 straight after reset.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

endmodule

// File: tb/tb_multiplier_32b_rr_arb.sv
// Bench for multiplier_32b_rr_arb: vector table, hand-written corner sequences and a randomized run
// against a transaction-level model. Honours MUL_CLR_EN when defined.
module tb_multiplier_32b_rr_arb;

    localparam int N = 4;
`ifdef MUL_CLR_EN
    localparam int CLR_CYC = 1;
`else
    localparam int CLR_CYC = 0;
`endif

    logic            iClk = 1'b0;
    logic            iRstN;
    logic [N-1:0]    iReqValid;
    logic [N-1:0]    oReqReady;
    logic [N*32-1:0] iReqData0;
    logic [N*32-1:0] iReqData1;
    logic            oMulEn;
    logic            oMulClr;
    logic [31:0]     oMulData0;
    logic [31:0]     oMulData1;
    logic [63:0]     iMulData;
    logic [N-1:0]    oRspValid;
    logic [63:0]     oRspData;
    logic            iRspReady;
    logic            oBusy;

    int n_checks = 0;
    int n_fail   = 0;

    multiplier_32b_rr_arb #(.NUM_REQ(N)) dut (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iReqValid (iReqValid),
        .oReqReady (oReqReady),
        .iReqData0 (iReqData0),
        .iReqData1 (iReqData1),
        .oMulEn    (oMulEn),
        .oMulClr   (oMulClr),
        .oMulData0 (oMulData0),
        .oMulData1 (oMulData1),
        .iMulData  (iMulData),
        .oRspValid (oRspValid),
        .oRspData  (oRspData),
        .iRspReady (iRspReady),
        .oBusy     (oBusy)
    );

    always #5 iClk = ~iClk;

    // Shared multiplier: registered product, synchronous clear, enable, holds when idle.
    logic [63:0] mul_q;
    assign iMulData = mul_q;
    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN)       mul_q <= '0;
        else if (oMulClr) mul_q <= '0;
        else if (oMulEn)  mul_q <= {32'b0, oMulData0} * {32'b0, oMulData1};
    end

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs [7];
    int   rr_order [6] = '{0, 1, 2, 3, 0, 1};

    logic        r_vld [N];
    logic [31:0] r_a [N];
    logic [31:0] r_b [N];
    int          m_ptr, last_acc, acc_cyc, idle_from, exp_req, cand_k, win, got, idx;
    logic        pending, in_clr, won;
    logic [63:0] exp_prod;
    logic [31:0] exp_a, exp_b;
    logic [N-1:0] exp_ready, exp_rspv;
    logic [63:0] exp_rspd;
    logic        exp_en, exp_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic sample();
        @(negedge iClk);
    endtask

    task automatic set_req(input int k, input logic v, input logic [31:0] a, input logic [31:0] b);
        iReqValid[k]          = v;
        iReqData0[32*k +: 32] = a;
        iReqData1[32*k +: 32] = b;
    endtask

    task automatic do_reset();
        iRstN     = 1'b0;
        iReqValid = '0;
        iRspReady = 1'b0;
        iReqData0 = '0;
        iReqData1 = '0;
        repeat (2) tick();
        iRstN = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 32'h0000_0003, 32'h0000_0005, 64'd15};
        vecs[1] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{3, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0};
        vecs[3] = '{2, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
        vecs[4] = '{3, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[6] = '{2, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};

        // Reset state
        do_reset();
        sample();
        check("reset ready", 64'(oReqReady), 64'(0));
        check("reset busy", 64'(oBusy), 64'(0));
        check("reset rsp valid", 64'(oRspValid), 64'(0));
        check("reset mul data0", 64'(oMulData0), 64'(0));
        check("reset mul en", 64'(oMulEn), 64'(0));
        tick();

        // Single-request vectors
        for (int v = 0; v < 7; v++) begin
            iReqValid = '0;
            iRspReady = 1'b1;
            set_req(vecs[v].req, 1'b1, vecs[v].a, vecs[v].b);
            sample();
            check($sformatf("v%0d ready", v), 64'(oReqReady), 64'(onehot(vecs[v].req)));
            check($sformatf("v%0d idle busy", v), 64'(oBusy), 64'(0));
            tick();
            set_req(vecs[v].req, 1'b0, $urandom, $urandom);
            sample();
            check($sformatf("v%0d mul en", v), 64'(oMulEn), 64'(1));
            check($sformatf("v%0d mul a", v), 64'(oMulData0), 64'(vecs[v].a));
            check($sformatf("v%0d mul b", v), 64'(oMulData1), 64'(vecs[v].b));
            check($sformatf("v%0d issue ready", v), 64'(oReqReady), 64'(0));
            check($sformatf("v%0d issue rspv", v), 64'(oRspValid), 64'(0));
            tick();
            sample();
            check($sformatf("v%0d rsp valid", v), 64'(oRspValid), 64'(onehot(vecs[v].req)));
            check($sformatf("v%0d rsp data", v), oRspData, vecs[v].prod);
            check($sformatf("v%0d resp mul en", v), 64'(oMulEn), 64'(0));
            tick();
            sample();
`ifdef MUL_CLR_EN
            check($sformatf("v%0d clr", v), 64'(oMulClr), 64'(1));
            check($sformatf("v%0d clr rspv", v), 64'(oRspValid), 64'(0));
            check($sformatf("v%0d clr busy", v), 64'(oBusy), 64'(1));
            tick();
            sample();
            check($sformatf("v%0d product cleared", v), iMulData, 64'(0));
`else
            check($sformatf("v%0d no clr", v), 64'(oMulClr), 64'(0));
`endif
            check($sformatf("v%0d done busy", v), 64'(oBusy), 64'(0));
            check($sformatf("v%0d done rspd", v), oRspData, 64'(0));
            tick();
        end

        // Round-robin fairness with all requesters continuously valid
        do_reset();
        iRspReady = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 1'b1, $urandom, $urandom);
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            sample();
            if (oReqReady != '0) begin
                idx = -1;
                for (int k = 0; k < N; k++) if (oReqReady[k]) idx = k;
                check("rr onehot", 64'($countones(oReqReady)), 64'(1));
                check($sformatf("rr grant %0d", got), 64'(idx), 64'(rr_order[got]));
                got++;
            end
            tick();
        end
        check("rr grant count", 64'(got), 64'(6));

        // Backpressure in RESP
        do_reset();
        set_req(2, 1'b1, 32'h0000_FFFF, 32'h0001_0001);
        sample();
        check("bp accept", 64'(oReqReady), 64'(onehot(2)));
        tick();
        set_req(2, 1'b0, 32'h0, 32'h0);
        set_req(0, 1'b1, 32'h0000_0002, 32'h0000_0003);
        sample();
        check("bp issue ready", 64'(oReqReady), 64'(0));
        tick();
        for (int i = 0; i < 5; i++) begin
            sample();
            check($sformatf("bp%0d rspv", i), 64'(oRspValid), 64'(onehot(2)));
            check($sformatf("bp%0d rspd", i), oRspData, 64'h0000_0000_FFFF_FFFF);
            check($sformatf("bp%0d ready", i), 64'(oReqReady), 64'(0));
            check($sformatf("bp%0d mul en", i), 64'(oMulEn), 64'(0));
            tick();
        end
        iRspReady = 1'b1;
        sample();
        check("bp release rspd", oRspData, 64'h0000_0000_FFFF_FFFF);
        tick();
`ifdef MUL_CLR_EN
        sample();
        check("bp clr ready", 64'(oReqReady), 64'(0));
        tick();
`endif
        sample();
        check("bp next grant", 64'(oReqReady), 64'(onehot(0)));
        tick();

        // Asynchronous reset in the middle of RESP
        do_reset();
        set_req(2, 1'b1, 32'd7, 32'd9);
        sample();
        check("rst accept", 64'(oReqReady), 64'(onehot(2)));
        tick();
        set_req(2, 1'b0, 32'h0, 32'h0);
        sample();
        tick();
        set_req(0, 1'b1, 32'h0000_0011, 32'h0000_0003);
        set_req(3, 1'b1, 32'h0000_0005, 32'h0000_0005);
        sample();
        check("rst pre rspv", 64'(oRspValid), 64'(onehot(2)));
        #1 iRstN = 1'b0;
        #1;
        check("rst ready", 64'(oReqReady), 64'(0));
        check("rst rspv", 64'(oRspValid), 64'(0));
        check("rst rspd", oRspData, 64'(0));
        check("rst mul en", 64'(oMulEn), 64'(0));
        check("rst mul clr", 64'(oMulClr), 64'(0));
        check("rst busy", 64'(oBusy), 64'(0));
        check("rst mul a", 64'(oMulData0), 64'(0));
        check("rst mul b", 64'(oMulData1), 64'(0));
        #1 iRstN = 1'b1;
        #1;
        check("rst first grant", 64'(oReqReady), 64'(onehot(0)));
        tick();
        set_req(0, 1'b0, 32'h0, 32'h0);
        iRspReady = 1'b1;
        sample();
        check("rst post mul a", 64'(oMulData0), 64'h11);
        tick();
        sample();
        check("rst post rspv", 64'(oRspValid), 64'(onehot(0)));
        check("rst post rspd", oRspData, 64'd51);
        tick();

        // Randomized run against a transaction-level model
        do_reset();
        for (int k = 0; k < N; k++) begin
            r_vld[k] = 1'b0;
            r_a[k]   = '0;
            r_b[k]   = '0;
        end
        m_ptr = 0; pending = 1'b0; idle_from = 0; last_acc = -1; acc_cyc = 0;
        exp_req = 0; exp_prod = '0; exp_a = '0; exp_b = '0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (last_acc >= 0) begin
                r_vld[last_acc] = 1'b0;
                last_acc = -1;
            end
            for (int k = 0; k < N; k++) begin
                if (!r_vld[k]) begin
                    if ($urandom_range(9) < 3) begin
                        r_vld[k] = 1'b1;
                        r_a[k]   = rand_op();
                        r_b[k]   = rand_op();
                    end
                end else if ($urandom_range(19) == 0) begin
                    r_vld[k] = 1'b0;
                end
                set_req(k, r_vld[k], r_a[k], r_b[k]);
            end
            iRspReady = ($urandom_range(9) < 6);
            sample();

            in_clr    = !pending && (c < idle_from);
            exp_ready = '0;
            exp_rspv  = '0;
            exp_rspd  = '0;
            exp_en    = 1'b0;
            exp_busy  = pending || in_clr;
            won       = 1'b0;
            win       = 0;
            if (pending) begin
                if (c >= acc_cyc + 2) begin
                    exp_rspv = onehot(exp_req);
                    exp_rspd = exp_prod;
                end
                if (c == acc_cyc + 1) exp_en = 1'b1;
            end else if (!in_clr) begin
                for (int i = 0; i < N; i++) begin
                    cand_k = (m_ptr + i) % N;
                    if (!won && r_vld[cand_k]) begin
                        won = 1'b1;
                        win = cand_k;
                    end
                end
                if (won) exp_ready = onehot(win);
            end

            check("rand ready", 64'(oReqReady), 64'(exp_ready));
            check("rand rspv", 64'(oRspValid), 64'(exp_rspv));
            check("rand rspd", oRspData, exp_rspd);
            check("rand mul en", 64'(oMulEn), 64'(exp_en));
            check("rand mul clr", 64'(oMulClr), 64'(in_clr));
            check("rand busy", 64'(oBusy), 64'(exp_busy));
            if (exp_en) begin
                check("rand mul a", 64'(oMulData0), 64'(exp_a));
                check("rand mul b", 64'(oMulData1), 64'(exp_b));
            end

            if (pending && (c >= acc_cyc + 2) && iRspReady) begin
                pending   = 1'b0;
                idle_from = c + 1 + CLR_CYC;
            end
            if (won) begin
                pending  = 1'b1;
                exp_req  = win;
                exp_a    = r_a[win];
                exp_b    = r_b[win];
                exp_prod = {32'b0, r_a[win]} * {32'b0, r_b[win]};
                acc_cyc  = c;
                m_ptr    = (win + 1) % N;
                last_acc = win;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
